// File: rtl/fpga_cfg_pkg.sv
// Shared FPGA configuration: fixed-point word format and per-block pipeline depths.
package fpga_cfg_pkg;

    // Signed Q(FP_QINT).(FP_QFRAC) word; FP_WIDTH = 1 + FP_QINT + FP_QFRAC.
    localparam int unsigned FP_WIDTH  = 32;
    localparam int unsigned FP_QINT   = 15;
    localparam int unsigned FP_QFRAC  = 16;

    // Per-block pipeline depths.
    localparam int unsigned FX_MUL_LATENCY = 2;

endpackage : fpga_cfg_pkg

// File: rtl/fx_mul.sv
// Pipelined signed fixed-point multiplier with round-half-up and saturation.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   valid_in, ready_out input handshake (operand pair a/b)
//   a, b                signed Q(QINT).(QFRAC) operands
//   valid_out, ready_in output handshake
//   result              signed Q(QINT).(QFRAC) product, held when valid_out=0
//
// Stage 1 forms the full 2*WIDTH product; the last stage rounds and saturates.
// With LATENCY=1 both happen in the single stage. The whole pipe advances
// together whenever the output slot is empty or being drained.
module fx_mul
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WIDTH   = FP_WIDTH,
    parameter int unsigned QINT    = FP_QINT,
    parameter int unsigned QFRAC   = FP_QFRAC,
    parameter int unsigned LATENCY = FX_MUL_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic signed [PW-1:0] MAX_V = PW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [PW-1:0] RND   = (QFRAC == 0) ? '0 : (PW'(1) << (QFRAC - 1));

    // Parameter sanity checks at elaboration.
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("fx_mul: LATENCY must be in 1..8");
    end
    if (WIDTH != 1 + QINT + QFRAC) begin : g_bad_format
        $error("fx_mul: WIDTH must equal 1+QINT+QFRAC");
    end

    // Round half toward +inf, arithmetic shift, clamp to the WIDTH-bit range.
    function automatic logic [WIDTH-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = (p + RND) >>> QFRAC;
        if (s > MAX_V) begin
            return MAX_V[WIDTH-1:0];
        end else if (s < MIN_V) begin
            return MIN_V[WIDTH-1:0];
        end
        return s[WIDTH-1:0];
    endfunction

    logic                 adv;
    logic [LATENCY-1:0]   vld;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_c;

    assign adv       = !valid_out || ready_in;
    assign ready_out = adv;
    assign valid_out = vld[LATENCY-1];

    assign a_ext  = PW'($signed(a));
    assign b_ext  = PW'($signed(b));
    assign prod_c = a_ext * b_ext;

    if (LATENCY == 1) begin : g_single
        // Single stage: multiply, round and saturate straight into result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld    <= '0;
                result <= '0;
            end else if (adv) begin
                vld[0] <= valid_in;
                if (valid_in) begin
                    result <= round_sat(prod_c);
                end
            end
        end
    end else begin : g_multi
        logic signed [PW-1:0] prod [LATENCY-1];

        // Product pipe; data registers only load behind a valid bit so bubbles
        // leave result holding the last emitted value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld    <= '0;
                result <= '0;
                for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                    prod[i] <= '0;
                end
            end else if (adv) begin
                vld <= {vld[LATENCY-2:0], valid_in};
                if (valid_in) begin
                    prod[0] <= prod_c;
                end
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    if (vld[i-1]) begin
                        prod[i] <= prod[i-1];
                    end
                end
                if (vld[LATENCY-2]) begin
                    result <= round_sat(prod[LATENCY-2]);
                end
            end
        end
    end

endmodule : fx_mul

// File: tb/tb_fx_mul.sv
// Self-checking bench for fx_mul (Q15.16, LATENCY=2): directed vectors plus a
// randomized handshake run scored against an arithmetic reference model.
module tb_fx_mul;

    localparam int unsigned W   = 32;
    localparam int unsigned QF  = 16;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          valid_out;
    logic          ready_in;
    logic [W-1:0]  result;

    int n_checks = 0;
    int n_errors = 0;
    int n_emitted = 0;

    logic [W-1:0] exp_q [$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_result = '0;

    fx_mul #(
        .WIDTH   (32),
        .QINT    (15),
        .QFRAC   (16),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact real-number product, rounded half up to the nearest LSB, clamped.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        longint r;
        p = longint'($signed(x)) * longint'($signed(y));
        r = (p + (64'sd1 <<< (QF - 1))) >>> QF;
        if (r > 64'sd2147483647)  r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[W-1:0];
    endfunction

    // Scoreboard and handshake-rule checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("ready_out_rule", {31'b0, ready_out}, {31'b0, ready_in || !valid_out});
            if (prev_stall) begin
                check("stall_valid", {31'b0, valid_out}, 32'd1);
                check("stall_result", result, prev_result);
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(ref_mul(a, b));
            end
            if (valid_out && ready_in) begin
                n_emitted++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {31'b0, valid_out}, 32'd0);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            prev_stall  = valid_out && !ready_in;
            prev_result = result;
        end
    end

    // Advance one clock; inputs change shortly after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Single pair with ready_in high: checks exact latency and the value.
    task automatic one_pair(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] exp);
        a = x; b = y; valid_in = 1'b1; ready_in = 1'b1;
        cyc();
        valid_in = 1'b0;
        check({tag, "_lat1"}, {31'b0, valid_out}, 32'd0);
        cyc();
        check({tag, "_lat2"}, {31'b0, valid_out}, 32'd1);
        check(tag, result, exp);
        cyc();
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {{15{r[16]}}, r[16:0]};
            2:       return {{8{r[23]}}, r[23:0]};
            default: return {r[31], {7{~r[31]}}, r[23:0]};
        endcase
    endfunction

    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    int           emitted_mark;

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; a = '0; b = '0;
        #3;
        check("rst_valid_out", {31'b0, valid_out}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ready_out", {31'b0, ready_out}, 32'd1);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Directed arithmetic vectors.
        one_pair("mul_1p5x2", 32'h0001_8000, 32'h0002_0000, 32'h0003_0000);
        one_pair("mul_neg", 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000);
        one_pair("round_half", 32'h0000_0001, 32'h0000_8000, 32'h0000_0001);
        one_pair("sat_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF);
        one_pair("sat_neg", 32'h8000_0000, 32'h0002_0000, 32'h8000_0000);
        one_pair("round_neg_half", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000);

        // Four back-to-back pairs with a 3-cycle output stall.
        for (int i = 0; i < 4; i++) begin
            sa[i] = rand_op();
            sb[i] = rand_op();
        end
        emitted_mark = n_emitted;
        ready_in = 1'b1; valid_in = 1'b1;
        a = sa[0]; b = sb[0];
        cyc();
        a = sa[1]; b = sb[1];
        cyc();
        ready_in = 1'b0;
        a = sa[2]; b = sb[2];
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready_out", {31'b0, ready_out}, 32'd0);
            check("stall_first", result, ref_mul(sa[0], sb[0]));
            cyc();
        end
        ready_in = 1'b1;
        cyc();
        a = sa[3]; b = sb[3];
        cyc();
        valid_in = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        check("stream_count", 32'(n_emitted - emitted_mark), 32'd4);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two pairs in flight.
        emitted_mark = n_emitted;
        valid_in = 1'b1; ready_in = 1'b1;
        a = 32'h0003_0000; b = 32'h0002_0000;
        cyc();
        a = 32'h0004_0000;
        cyc();
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", {31'b0, valid_out}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_ready_out", {31'b0, ready_out}, 32'd1);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_quiet", {31'b0, valid_out}, 32'd0);
            cyc();
        end
        check("post_rst_count", 32'(n_emitted - emitted_mark), 32'd0);
        one_pair("post_rst_one", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);

        // Randomized traffic with random back-pressure.
        for (int k = 0; k < 400; k++) begin
            valid_in = ($urandom_range(0, 9) < 7);
            ready_in = ($urandom_range(0, 9) < 6);
            a = rand_op();
            b = rand_op();
            cyc();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 2 * int'(LAT) + 4; k++) cyc();
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", {31'b0, valid_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fx_mul

// File: doc/fx_mul.md
FX_MUL -- requirements
Module: fx_mul

Interface
REQ-001 SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH (32), total signed word width.
REQ-002 SHALL have parameter QINT, default fpga_cfg_pkg::FP_QINT (15), integer bits excluding sign.
REQ-003 SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC (16), fractional bits; WIDTH = 1+QINT+QFRAC.
REQ-004 SHALL have parameter LATENCY, default 2, pipeline depth in cycles; legal range 1..8.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port valid_in, input, 1, operands a/b valid.
REQ-008 Port ready_out, output, 1, block can accept an operand pair this cycle.
REQ-009 Port valid_out, output, 1, result valid.
REQ-010 Port ready_in, input, 1, downstream accepts result.
REQ-011 Port a, input, WIDTH, signed two's-complement Q(QINT).(QFRAC) operand.
REQ-012 Port b, input, WIDTH, signed Q operand, same format.
REQ-013 Port result, output, WIDTH, signed Q product, same format.

Function
REQ-014 SHALL compute full 2*WIDTH signed product a*b.
REQ-015 SHALL round to nearest: add 2^(QFRAC-1) to product, then arithmetic shift right by QFRAC (ties round toward +inf).
REQ-016 SHALL saturate shifted value to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around.
REQ-017 Transfer in occurs when valid_in && ready_out; transfer out when valid_out && ready_in.
REQ-018 SHALL be a LATENCY-stage pipeline with a valid bit per stage; absent stalls, result appears with valid_out exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL sustain one accepted pair per cycle when ready_in is held high.
REQ-020 Pipeline advances when last stage is empty or ready_in=1; otherwise all stages hold.
REQ-021 ready_out = ready_in || !valid_out (combinational, no dependency on valid_in).
REQ-022 While valid_out && !ready_in, result and valid_out SHALL remain stable every cycle.
REQ-023 Bubbles SHALL propagate without emitting valid_out; data order SHALL be preserved (FIFO order).
REQ-024 Simultaneous accept and emit in one cycle SHALL lose no data.
REQ-025 result SHALL hold last emitted value when valid_out=0.

Reset
REQ-026 On rst_n low, all stage valid bits and valid_out SHALL clear to 0 immediately, asynchronously.
REQ-027 On reset, result and all data stage registers SHALL clear to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight products; none emitted after release.
REQ-029 ready_out SHALL be 1 during and after reset (follows REQ-021 with valid_out=0).

Structure
REQ-030 FP_WIDTH, FP_QINT, FP_QFRAC and per-block latencies SHALL reside in shared package fpga_cfg_pkg.
REQ-031 Single module; no sub-modules; product register may map to DSP blocks (multiply in stage 1, round/saturate in last stage).

Verification (Q15.16, LATENCY=2)
REQ-032 a=0x00018000 (1.5), b=0x00020000 (2.0), ready_in=1 -> result=0x00030000, valid_out exactly 2 cycles after accept.
REQ-033 a=0xFFFE8000 (-1.5), b=0x00020000 -> result=0xFFFD0000; a=0x00000001, b=0x00008000 -> result=0x00000001 (round half up).
REQ-034 a=0x7FFF0000, b=0x00020000 -> result=0x7FFFFFFF; a=0x80000000, b=0x00020000 -> result=0x80000000 (saturation).
REQ-035 Stream 4 pairs back-to-back, ready_in low for 3 cycles when first result valid -> result stable, ready_out=0 while stalled, all 4 results emitted in order, no drops or duplicates.
REQ-036 Assert rst_n low with 2 pairs in flight -> valid_out=0 immediately, result=0, no output after release; next pair 0x00010000*0x00010000 -> 0x00010000.
